// File: rtl/wb_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stream_pkg
// Purpose  : Shared Wishbone cycle-type constants and DMA FSM state encoding
//            for wb_stream_reader.
// Revision : 1.0
// ============================================================================
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo
// Purpose  : First-word-fall-through synchronous FIFO with flush and count.
// Revision : 1.0
// ============================================================================
module stream_fifo #(
    parameter int FIFO_AW = 5,
    parameter int WB_DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WB_DW-1:0]   wdata,
    input  logic               pop,
    input  logic               flush,
    output logic [WB_DW-1:0]   rdata,
    output logic               full,
    output logic [FIFO_AW:0]   count
);

    localparam int               DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/wb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : wb_stream_reader
// Purpose  : Stream-to-memory DMA writing FIFO-buffered words with Wishbone
//            incrementing bursts. Define WB_STREAM_READER_WRAP_EN for
//            circular-buffer operation.
// Revision : 1.0
// ============================================================================
module wb_stream_reader #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    input  logic [WB_DW-1:0]   stream_s_data_i,
    input  logic               stream_s_valid_i,
    output logic               stream_s_ready_o,
    input  logic [WB_AW-1:0]   cfg_start_adr_i,
    input  logic [WB_AW-1:0]   cfg_buf_size_i,
    input  logic [15:0]        cfg_burst_size_i,
    input  logic               cfg_enable_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    import wb_stream_pkg::*;

    localparam int             WSB      = WB_DW / 8;
    localparam int             WSB_LG   = $clog2(WSB);
    localparam int             DEPTH    = 2 ** FIFO_AW;
    localparam int             LW       = (WB_AW > 17) ? WB_AW : 17;
    localparam logic [WB_AW-1:0] ADR_MASK = WB_AW'(WSB - 1);

    state_t             state, state_nxt;
    logic [WB_AW-1:0]   adr, adr_nxt;
    logic [WB_AW-1:0]   rem, rem_nxt;
    logic [LW-1:0]      beats, beats_nxt;
    logic [15:0]        burst_q, burst_nxt;
    logic               err_q, err_nxt;
    logic               done_q, done_nxt;
    logic               ready_en;
`ifdef WB_STREAM_READER_WRAP_EN
    logic [WB_AW-1:0]   start_q, start_nxt;
    logic [WB_AW-1:0]   words_q, words_nxt;
`endif

    logic [WB_AW-1:0]   cfg_words;
    logic [LW-1:0]      blen;
    logic               cyc;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic [FIFO_AW:0]   fifo_count;
    logic [WB_DW-1:0]   fifo_head;
    logic               unused_ok;

    assign unused_ok = ^{wbm_dat_i, wbm_rty_i};
    assign cfg_words = cfg_buf_size_i >> WSB_LG;

    // ready is registered state only; held low until the first edge out of reset.
    assign stream_s_ready_o = ready_en && !fifo_full;

    stream_fifo #(
        .FIFO_AW (FIFO_AW),
        .WB_DW   (WB_DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stream_s_valid_i && stream_s_ready_o),
        .wdata (stream_s_data_i),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_head),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        blen = (burst_q == 16'd0) ? LW'(1) : LW'(burst_q);
        if (blen > LW'(MAX_BURST_LEN)) blen = LW'(MAX_BURST_LEN);
        if (blen > LW'(DEPTH))         blen = LW'(DEPTH);
        if (blen > LW'(rem))           blen = LW'(rem);
    end

    always_comb begin
        state_nxt  = state;
        adr_nxt    = adr;
        rem_nxt    = rem;
        beats_nxt  = beats;
        burst_nxt  = burst_q;
        err_nxt    = err_q;
        done_nxt   = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
`ifdef WB_STREAM_READER_WRAP_EN
        start_nxt  = start_q;
        words_nxt  = words_q;
`endif
        case (state)
            ST_IDLE: begin
                if (cfg_enable_i) begin
                    err_nxt   = 1'b0;
                    adr_nxt   = cfg_start_adr_i & ~ADR_MASK;
                    rem_nxt   = cfg_words;
                    burst_nxt = cfg_burst_size_i;
`ifdef WB_STREAM_READER_WRAP_EN
                    start_nxt = cfg_start_adr_i & ~ADR_MASK;
                    words_nxt = cfg_words;
`endif
                    if (cfg_words == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (LW'(fifo_count) >= blen) begin
                    beats_nxt = blen;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wbm_err_i) begin
                    err_nxt    = 1'b1;
                    fifo_flush = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wbm_ack_i) begin
                    fifo_pop  = 1'b1;
                    adr_nxt   = adr + WB_AW'(WSB);
                    rem_nxt   = rem - WB_AW'(1);
                    beats_nxt = beats - LW'(1);
                    if (beats == LW'(1)) begin
                        if (rem == WB_AW'(1)) begin
`ifdef WB_STREAM_READER_WRAP_EN
                            if (cfg_enable_i) begin
                                adr_nxt   = start_q;
                                rem_nxt   = words_q;
                                state_nxt = ST_WAIT;
                            end else begin
                                state_nxt = ST_DONE;
                            end
`else
                            state_nxt = ST_DONE;
`endif
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            adr      <= '0;
            rem      <= '0;
            beats    <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_en <= 1'b0;
`ifdef WB_STREAM_READER_WRAP_EN
            start_q  <= '0;
            words_q  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            adr      <= adr_nxt;
            rem      <= rem_nxt;
            beats    <= beats_nxt;
            burst_q  <= burst_nxt;
            err_q    <= err_nxt;
            done_q   <= done_nxt;
            ready_en <= 1'b1;
`ifdef WB_STREAM_READER_WRAP_EN
            start_q  <= start_nxt;
            words_q  <= words_nxt;
`endif
        end
    end

    assign cyc       = (state == ST_BURST);
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = cyc;
    assign wbm_sel_o = cyc ? '1 : '0;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = fifo_head;
    assign wbm_bte_o = BTE_LINEAR;
    assign wbm_cti_o = !cyc ? CTI_CLASSIC : ((beats == LW'(1)) ? CTI_EOB : CTI_INC);
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stream_reader
// Purpose  : Self-checking bench for wb_stream_reader (scoreboarded stream
//            words against Wishbone write beats, table-driven transfers).
// Revision : 1.0
// ============================================================================
module tb_wb_stream_reader;

    typedef struct {
        logic [31:0] start;
        logic [31:0] buf_size;
        logic [15:0] burst;
        int          nwords;
        int          stall_pct;
        int          ack_pct;
        int          rty_pct;
        int          exp_beats;
        int          exp_bursts;
        int          exp_left;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr, dat_o, dat_i, s_data, cfg_start, cfg_size;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        s_valid, s_ready, enable, busy, done, err_flag;
    logic [15:0] cfg_burst;
    logic        ack_en, rty_en, err_en;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_base;
    int m_words, m_idx, m_pos, m_blen, m_burst;
    int beats_acked, burst_cnt, done_cnt;
    int ack_pct = 100, rty_pct = 0, err_at = -1;
    logic cyc_prev = 1'b0;
    logic err_seen = 1'b0;
    logic [31:0] next_word = 32'hA000_0001;

    always #5 clk = ~clk;

    wb_stream_reader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wbm_adr_o        (adr),
        .wbm_dat_o        (dat_o),
        .wbm_sel_o        (sel),
        .wbm_we_o         (we),
        .wbm_cyc_o        (cyc),
        .wbm_stb_o        (stb),
        .wbm_cti_o        (cti),
        .wbm_bte_o        (bte),
        .wbm_dat_i        (dat_i),
        .wbm_ack_i        (ack),
        .wbm_err_i        (err),
        .wbm_rty_i        (rty),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_ready_o (s_ready),
        .cfg_start_adr_i  (cfg_start),
        .cfg_buf_size_i   (cfg_size),
        .cfg_burst_size_i (cfg_burst),
        .cfg_enable_i     (enable),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err_flag)
    );

    assign ack = cyc && stb && ack_en && !err_en;
    assign rty = cyc && stb && rty_en && !err_en;
    assign err = cyc && stb && err_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave response model: random ack/retry, error injected on a chosen beat.
    initial begin
        int r;
        ack_en = 1'b0; rty_en = 1'b0; err_en = 1'b0;
        forever begin
            @(posedge clk); #1;
            r      = $urandom_range(99);
            ack_en = (r < ack_pct);
            rty_en = !ack_en && (r < ack_pct + rty_pct);
            err_en = (err_at >= 0) && (beats_acked == err_at);
        end
    end

    // Monitor + scoreboard: pop-before-push keeps same-cycle push/pop ordered.
    always @(negedge clk) begin
        logic [31:0] exp_d, exp_a;
        logic [2:0]  exp_cti;
        int          rem, b;
        if (rst_n) begin
            if (cyc && ack) begin
                if (m_pos == 0) begin
                    rem = m_words - m_idx;
                    b   = (m_burst == 0) ? 1 : m_burst;
                    if (b > 128) b = 128;
                    if (b > 32)  b = 32;
                    if (b > rem) b = rem;
                    m_blen = b;
                end
                exp_cti = (m_pos == m_blen - 1) ? 3'b111 : 3'b010;
                exp_a   = m_base + 32'(4 * m_idx);
                exp_d   = 32'h0;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) exp_d = exp_q.pop_front();
                check("beat_data", dat_o, exp_d);
                check("beat_adr", adr, exp_a);
                check("beat_cti", cti, exp_cti);
                check("beat_ctl", {we, stb, sel, bte}, {1'b1, 1'b1, 4'hF, 2'b00});
                beats_acked++;
                m_pos++;
                m_idx++;
                if (m_pos == m_blen)  m_pos = 0;
                if (m_idx == m_words) m_idx = 0;
            end
            if (cyc && err) begin
                err_seen = 1'b1;
                exp_q.delete();
            end else if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
            end
            if (cyc && !cyc_prev) burst_cnt++;
            if (done) done_cnt++;
        end
        cyc_prev = cyc;
    end

    task automatic produce(input int n, input int stall_pct, input int max_cycles, output int sent);
        int   k = 0;
        logic fire;
        sent = 0;
        while (sent < n && k < max_cycles) begin
            s_valid = ($urandom_range(99) >= stall_pct);
            s_data  = next_word;
            @(negedge clk);
            fire = s_valid && s_ready;
            @(posedge clk); #1;
            if (fire) begin
                sent++;
                next_word = next_word + 32'h0001_1001;
            end
            k++;
        end
        s_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] st, input logic [31:0] sz, input logic [15:0] bu,
                              input logic hold);
        m_base    = st & ~32'h3;
        m_words   = int'(sz >> 2);
        m_idx     = 0;
        m_pos     = 0;
        m_burst   = int'(bu);
        cfg_start = st;
        cfg_size  = sz;
        cfg_burst = bu;
        enable    = 1'b1;
        @(posedge clk); #1;
        if (!hold) enable = 1'b0;
        // Config scribbled while busy must have no effect.
        cfg_start = 32'hDEAD_BEE0;
        cfg_size  = 32'h4;
        cfg_burst = 16'h1;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int k = 0;
        while (busy && k < max_cycles) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_idle_timeout"}, busy, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   sent, k;

        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   sent, k;

        s_valid = 1'b0; s_data = '0; dat_i = '0; enable = 1'b0;
        cfg_start = '0; cfg_size = '0; cfg_burst = '0;
        m_base = '0; m_words = 0; m_idx = 0; m_pos = 0; m_blen = 1; m_burst = 0;
        beats_acked = 0; burst_cnt = 0; done_cnt = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready, 0);
        check("rst_cyc", {cyc, stb, we}, 3'b000);
        check("rst_status", {busy, done, err_flag}, 3'b000);
        check("rst_bus", {adr, sel, cti, bte}, 41'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ready_after_reset", s_ready, 1);

        //          start         buf     burst  n  stl ack rty beats bursts left
        vecs[0] = '{32'h40,       32'd128, 16'd8,   32, 0,  100, 0,  32, 4,  0};
        vecs[1] = '{32'h40,       32'd20,  16'd8,   5,  0,  100, 0,  5,  1,  0};
        vecs[2] = '{32'h100,      32'd64,  16'd0,   16, 0,  60,  0,  16, 16, 0};
        vecs[3] = '{32'h1003,     32'd48,  16'd5,   12, 40, 50,  20, 12, 3,  0};
        vecs[4] = '{32'h300,      32'd40,  16'd200, 14, 0,  100, 0,  10, 1,  4};
        vecs[5] = '{32'h200,      32'd16,  16'd4,   0,  0,  100, 0,  4,  1,  0};
        vecs[6] = '{32'hFFFF_FFF8, 32'd22, 16'd3,   5,  0,  100, 0,  5,  2,  0};

        for (int i = 0; i < 7; i++) begin
            ack_pct = vecs[i].ack_pct;
            rty_pct = vecs[i].rty_pct;
            beats_acked = 0; burst_cnt = 0; done_cnt = 0;
            start_xfer(vecs[i].start, vecs[i].buf_size, vecs[i].burst, 1'b0);
            produce(vecs[i].nwords, vecs[i].stall_pct, 4000, sent);
            check("vec_sent", sent, vecs[i].nwords);
            wait_idle(2000, "vec");
            @(posedge clk); #1;
            check("vec_beats", beats_acked, vecs[i].exp_beats);
            check("vec_bursts", burst_cnt, vecs[i].exp_bursts);
            check("vec_done", done_cnt, 1);
            check("vec_left", exp_q.size(), vecs[i].exp_left);
        end
        rty_pct = 0;
        ack_pct = 100;

        // FIFO fills to exactly 32 with no transfer running.
        produce(40, 0, 45, sent);
        check("fill_sent", sent, 32);
        check("fill_ready_low", s_ready, 0);
        beats_acked = 0; burst_cnt = 0; done_cnt = 0;
        start_xfer(32'h800, 32'd128, 16'd16, 1'b0);
        wait_idle(500, "drain");
        @(posedge clk); #1;
        check("drain_beats", beats_acked, 32);
        check("drain_bursts", burst_cnt, 2);
        check("drain_ready", s_ready, 1);

        // Zero-length buffer: done pulse, no bus cycle.
        burst_cnt = 0; done_cnt = 0;
        start_xfer(32'h40, 32'd0, 16'd8, 1'b0);
        k = 0;
        while (!done && k < 5) begin
            @(posedge clk); #1;
            k++;
        end
        check("buf0_done_latency", k <= 1, 1);
        wait_idle(10, "buf0");
        repeat (2) @(posedge clk);
        #1;
        check("buf0_done_count", done_cnt, 1);
        check("buf0_no_cycle", burst_cnt, 0);

        // Bus error on the third beat.
        beats_acked = 0; done_cnt = 0; err_seen = 1'b0;
        err_at = 2;
        start_xfer(32'h40, 32'd128, 16'd8, 1'b0);
        produce(8, 0, 100, sent);
        k = 0;
        while (!err_seen && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("err_seen", err_seen, 1);
        @(posedge clk); #1;
        err_at = -1;
        check("err_cyc_drop", cyc, 0);
        check("err_status", {err_flag, busy}, 2'b10);
        repeat (5) @(posedge clk);
        #1;
        check("err_no_done", done_cnt, 0);
        check("err_beats", beats_acked, 2);
        check("err_sticky", err_flag, 1);
        beats_acked = 0;
        start_xfer(32'h80, 32'd16, 16'd4, 1'b0);
        check("err_cleared", err_flag, 0);
        produce(4, 0, 100, sent);
        wait_idle(200, "after_err");
        check("after_err_beats", beats_acked, 4);

        // Asynchronous reset in the middle of a stalled burst.
        ack_pct = 0;
        start_xfer(32'h40, 32'd128, 16'd8, 1'b0);
        produce(8, 0, 100, sent);
        k = 0;
        while (!cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_cyc_up", cyc, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_cyc_drop", {cyc, stb, busy}, 3'b000);
        check("rstmid_ready", s_ready, 0);
        exp_q.delete();
        m_idx = 0; m_pos = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_pct = 100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_ready_back", s_ready, 1);
        beats_acked = 0; burst_cnt = 0;
        start_xfer(32'h500, 32'd4, 16'd1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("rstmid_fifo_empty", {burst_cnt[7:0], busy}, {8'd0, 1'b1});
        produce(1, 0, 20, sent);
        wait_idle(50, "rstmid");
        check("rstmid_beats", beats_acked, 1);

`ifdef WB_STREAM_READER_WRAP_EN
        // Circular mode: second pass rewrites the buffer start.
        beats_acked = 0; done_cnt = 0;
        start_xfer(32'h40, 32'd32, 16'd8, 1'b1);
        produce(8, 0, 100, sent);
        k = 0;
        while (done_cnt == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("wrap_first_done", done_cnt, 1);
        check("wrap_still_busy", busy, 1);
        enable = 1'b0;
        produce(8, 0, 100, sent);
        wait_idle(200, "wrap");
        @(posedge clk); #1;
        check("wrap_done_count", done_cnt, 2);
        check("wrap_beats", beats_acked, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
